// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - synchronise, polarity-correct and debounce raw board inputs
module board_input_conditioner #(
    parameter int              Width          = 4,
    parameter int              SyncStages     = 2,
    parameter int              DebounceCycles = 50000,
    parameter logic [Width-1:0] InvertMask    = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] raw_i,
    input  logic [Width-1:0] changed_clr_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] changed_o
);

    localparam int              CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    // sync_q[SyncStages-1] is the synchroniser output; it resets to the pin idle value
    logic [Width-1:0] sync_q [SyncStages];
    logic [Width-1:0] s;
    logic [CntW-1:0]  cnt_q [Width];
    logic [Width-1:0] flip;

    assign s = sync_q[SyncStages-1] ^ InvertMask;

    // Synchroniser chain for every channel
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_q[k] <= InvertMask;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int k = 1; k < SyncStages; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // A channel flips once its mismatch has persisted for the full debounce window
    always_comb begin
        flip = '0;
        for (int i = 0; i < Width; i++) begin
            flip[i] = (s[i] != level_o[i]) && (cnt_q[i] == CntLast);
        end
    end

    // Per-channel mismatch run counters; cleared on match or on flip, so they never wrap
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Width; i++) begin
                if ((s[i] == level_o[i]) || flip[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Registered level, edge pulses and sticky change flags (a flip beats a clear)
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            level_o   <= '0;
            rise_o    <= '0;
            fall_o    <= '0;
            changed_o <= '0;
        end else begin
            level_o   <= level_o ^ flip;
            rise_o    <= flip & s;
            fall_o    <= flip & ~s;
            changed_o <= flip | (changed_o & ~changed_clr_i);
        end
    end

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - directed bench with window-based reference model
module tb_board_input_conditioner;

    localparam int         W    = 4;
    localparam int         SS   = 2;
    localparam int         DC   = 8;
    localparam logic [3:0] MASK = 4'b1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = MASK;
    logic [W-1:0] clr = '0;
    logic [W-1:0] level, rise, fall, changed;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: raw pin history and a window of the last DC polarity-corrected samples
    logic [W-1:0] rhist [SS];
    logic [W-1:0] win   [DC];
    logic [W-1:0] m_level, m_rise, m_fall, m_changed;

    board_input_conditioner #(
        .Width(W), .SyncStages(SS), .DebounceCycles(DC), .InvertMask(MASK)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .raw_i(raw), .changed_clr_i(clr),
        .level_o(level), .rise_o(rise), .fall_o(fall), .changed_o(changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) rhist[k] = MASK;
        for (int k = 0; k < DC; k++) win[k] = '0;
        m_level   = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = '0;
    endtask

    // A level flips when every one of the last DC corrected samples disagrees with it
    task automatic model_step(input logic [W-1:0] r, input logic [W-1:0] c);
        logic [W-1:0] s_now, flip;
        s_now = rhist[SS-1] ^ MASK;
        for (int k = SS - 1; k > 0; k--) rhist[k] = rhist[k-1];
        rhist[0] = r;
        for (int k = DC - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = s_now;
        flip = '1;
        for (int k = 0; k < DC; k++) flip = flip & (win[k] ^ m_level);
        m_rise    = flip & ~m_level;
        m_fall    = flip & m_level;
        m_level   = m_level ^ flip;
        m_changed = flip | (m_changed & ~c);
    endtask

    // Advance the model on every edge and compare all outputs on the following falling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step(raw, clr);
            @(negedge clk);
            if (rst) model_reset();
            chk("level",   level,   m_level);
            chk("rise",    rise,    m_rise);
            chk("fall",    fall,    m_fall);
            chk("changed", changed, m_changed);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    initial begin
        // Reset with idle inputs, then idle for 50 cycles
        tick(5);
        rst = 1'b0;
        tick(50);
        chk("lit_idle_level",   level,   4'b0000);
        chk("lit_idle_changed", changed, 4'b0000);

        // Channel 0 press: level rises after edge 10
        raw = 4'b1001;
        tick(9);
        chk("lit_c0_before", level, 4'b0000);
        tick(1);
        chk("lit_c0_level",   level,   4'b0001);
        chk("lit_c0_rise",    rise,    4'b0001);
        chk("lit_c0_changed", changed, 4'b0001);
        tick(1);
        chk("lit_c0_rise_end", rise, 4'b0000);
        clr = 4'b0001;
        tick(1);
        chk("lit_c0_cleared", changed, 4'b0000);
        clr = 4'b0000;

        // Channel 0 release with clear on the flip edge: set wins, then clear takes effect
        raw = 4'b1000;
        tick(9);
        chk("lit_c0_rel_before", level, 4'b0001);
        clr = 4'b0001;
        tick(1);
        chk("lit_c0_fall",        fall,    4'b0001);
        chk("lit_c0_set_wins",    changed, 4'b0001);
        tick(1);
        chk("lit_c0_clear_after", changed, 4'b0000);
        clr = 4'b0000;

        // Channel 1: 7-cycle glitch rejected, 8-cycle pulse accepted
        raw = 4'b1010;
        tick(7);
        raw = 4'b1000;
        tick(15);
        chk("lit_c1_glitch_level",   level,   4'b0000);
        chk("lit_c1_glitch_changed", changed, 4'b0000);
        raw = 4'b1010;
        tick(8);
        raw = 4'b1000;
        tick(2);
        chk("lit_c1_level", level, 4'b0010);
        chk("lit_c1_rise",  rise,  4'b0010);
        tick(20);

        // Channel 3 active-low press and release
        raw = 4'b0000;
        tick(9);
        chk("lit_c3_before", level, 4'b0000);
        tick(1);
        chk("lit_c3_level", level, 4'b1000);
        chk("lit_c3_rise",  rise,  4'b1000);
        raw = 4'b1000;
        tick(9);
        chk("lit_c3_no_fall_yet", fall, 4'b0000);
        tick(1);
        chk("lit_c3_fall",  fall,  4'b1000);
        chk("lit_c3_level_low", level, 4'b0000);

        // Channel 2: reset at count 5, then full latency again with input held
        raw = 4'b1100;
        tick(7);
        chk("lit_c2_pending", level, 4'b0000);
        rst = 1'b1;
        #1;
        chk("lit_rst_level",   level,   4'b0000);
        chk("lit_rst_rise",    rise,    4'b0000);
        chk("lit_rst_fall",    fall,    4'b0000);
        chk("lit_rst_changed", changed, 4'b0000);
        tick(1);
        rst = 1'b0;
        tick(9);
        chk("lit_c2_before", level, 4'b0000);
        tick(1);
        chk("lit_c2_level",   level,   4'b0100);
        chk("lit_c2_rise",    rise,    4'b0100);
        chk("lit_c2_changed", changed, 4'b0100);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
